m_store_unit: RTL
=================

M_STORE_UNIT -- requirements
Module: m_store_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset: clk in, reset in.
REQ-002 Ports SHALL be, in this order:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low.
- St_Valid  input  1  store request from the M stage.
- St_Op  input  3  store type: 3'b000 sw, 3'b001 sh, 3'b010 sb; any other value means no store.
- St_Addr  input  32  byte address.
- St_Din  input  32  register data, right-justified.
- St_Ready  output  1  buffer can accept a store this cycle.
- Exc_AdES  output  1  store address-alignment exception.
- Bus_Req  output  1  write request to the data bus.
- Bus_Addr  output  32  word-aligned address; bits [1:0] are 2'b00.
- Bus_Wdata  output  32  lane-replicated write data.
- Bus_Byteen  output  4  byte lane enables.
- Bus_Ack  input  1  bus accepted the current request.
- Idle  output  1  buffer is empty.

Function
REQ-003 Legal accept condition: St_Valid, St_Ready and a legal St_Op all high, and Exc_AdES low.
REQ-004 A legal accept SHALL push one entry {word address, Wdata, Byteen} into a 2-entry FIFO at the rising edge.
REQ-005 Byte enables:
- sw: 4'b1111.
- sh: St_Addr[1] ? 4'b1100 : 4'b0011.
- sb: 4'b0001 << St_Addr[1:0].
REQ-006 Write data:
- sw: St_Din.
- sh: {2{St_Din[15:0]}}.
- sb: {4{St_Din[7:0]}}.
REQ-007 St_Ready SHALL be high when the FIFO holds fewer than 2 entries, and SHALL NOT depend on Bus_Ack.
REQ-008 Bus_Req SHALL be high exactly when the FIFO is non-empty. Bus_Addr, Bus_Wdata and Bus_Byteen SHALL present the head entry.
REQ-009 The bus signals SHALL stay stable while Bus_Req is high and Bus_Ack is low.
REQ-010 Bus_Ack high with Bus_Req high SHALL pop the head at the rising edge. Bus_Ack while Bus_Req is low SHALL be ignored.
REQ-011 Latency SHALL be one cycle: an entry accepted at edge N appears on the bus after edge N when the FIFO was empty before N.
REQ-012 A simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-013 Read and write pointers SHALL be 1 bit each and wrap modulo 2; the count SHALL range 0..2.
REQ-014 Idle SHALL equal (count == 0). It is used to drain stores before an interrupt or eret.
REQ-015 Exc_AdES SHALL be combinational: St_Valid and ((sw and St_Addr[1:0] != 0) or (sh and St_Addr[0])). A store that raises it SHALL NOT be enqueued.
REQ-016 An illegal St_Op with St_Valid high SHALL cause no push and no exception.

Reset
REQ-017 While reset is low, the FIFO SHALL be cleared asynchronously.
REQ-018 Reset values: St_Ready=1, Bus_Req=0, Bus_Addr=0, Bus_Wdata=0, Bus_Byteen=0, Idle=1.
REQ-019 Reset asserted mid-transaction SHALL discard all buffered stores and drop Bus_Req immediately, without waiting for the clock.

Configuration
REQ-020 Macro STORE_ALIGN_CHECK_EN:
- Defined: REQ-015 applies.
- Undefined: Exc_AdES SHALL be tied to 0 and misaligned stores SHALL be enqueued using REQ-005/REQ-006 unchanged, with the address aligned down.

Structure
REQ-021 A shared package SHALL hold the St_Op encodings, the byte-enable constants and the FIFO depth (2).
REQ-022 The FIFO SHALL be a sub-module store_fifo (2 entries, 68-bit payload). Alignment and lane logic SHALL live in m_store_unit.

Verification
REQ-023 sb, Addr=0x0000_3003, Din=0x1234_56AB, Ack held high -> next cycle Bus_Req=1, Bus_Addr=0x0000_3000, Byteen=4'b1000, Wdata=0xABAB_ABAB.
REQ-024 sh, Addr=0x0000_0102, Din=0x0000_BEEF -> Byteen=4'b1100, Wdata=0xBEEF_BEEF.
REQ-025 Two sw pushes with Bus_Ack=0 -> St_Ready=0 and Idle=0; Ack high for 2 cycles -> entries emerge in push order, then Idle=1.
REQ-026 With STORE_ALIGN_CHECK_EN defined: sw at Addr=0x0000_0006 -> Exc_AdES=1, no push, Bus_Req stays 0. With it undefined -> Exc_AdES=0 and Bus_Addr=0x0000_0004.
REQ-027 Full FIFO, Bus_Req=1, reset pulled low between clock edges -> Bus_Req=0 at once; after release, St_Ready=1 and Idle=1.
REQ-028 Count=1 with simultaneous push and Ack -> count stays 1, the new entry becomes head, and pointers wrap correctly over 4 consecutive cycles.

Source files
------------

// File: rtl/m_store_unit_pkg.sv
// Shared store-unit definitions: St_Op encodings, lane enables, buffer depth and entry layout.
package m_store_unit_pkg;

    localparam logic [2:0] ST_OP_SW = 3'b000;
    localparam logic [2:0] ST_OP_SH = 3'b001;
    localparam logic [2:0] ST_OP_SB = 3'b010;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    localparam int FIFO_DEPTH = 2;
    localparam int ENTRY_W    = 68;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } st_entry_t;

    function automatic logic st_op_legal(input logic [2:0] op);
        return (op == ST_OP_SW) || (op == ST_OP_SH) || (op == ST_OP_SB);
    endfunction

endpackage

// File: rtl/m_store_unit_store_fifo.sv
// Purpose: 2-entry store buffer holding {word address, write data, byte enables}.
// Latency: a push is visible at the head one cycle later when the buffer was empty.
// Backpressure: push_rdy_o drops when both entries are occupied; pop_rdy_i is ignored while empty.
module store_fifo
    import m_store_unit_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push_vld_i,
    input  st_entry_t push_dat_i,
    output logic      push_rdy_o,
    output logic      pop_vld_o,
    input  logic      pop_rdy_i,
    output st_entry_t pop_dat_o
);

    st_entry_t   mem_q [FIFO_DEPTH];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        push, pop;

    always_comb begin
        push_rdy_o = (cnt_q != 2'(FIFO_DEPTH));
        pop_vld_o  = (cnt_q != 2'd0);
        pop_dat_o  = mem_q[rd_ptr_q];
        push       = push_vld_i & push_rdy_o;
        pop        = pop_vld_o & pop_rdy_i;
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Storage is cleared too so the bus outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/m_store_unit.sv
// Purpose: M-stage store unit: lane/alignment formatting into a 2-entry buffer draining to the data bus.
// Latency: an accepted store reaches Bus_Req one cycle later when the buffer was empty.
// Backpressure: St_Ready low while the buffer is full (independent of Bus_Ack); head holds until Bus_Ack.
// Build option: STORE_ALIGN_CHECK_EN enables the misaligned-store exception (Exc_AdES).
module m_store_unit
    import m_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        St_Valid,
    input  logic [2:0]  St_Op,
    input  logic [31:0] St_Addr,
    input  logic [31:0] St_Din,
    output logic        St_Ready,
    output logic        Exc_AdES,
    output logic        Bus_Req,
    output logic [31:0] Bus_Addr,
    output logic [31:0] Bus_Wdata,
    output logic [3:0]  Bus_Byteen,
    input  logic        Bus_Ack,
    output logic        Idle
);

    st_entry_t new_entry;
    st_entry_t head;
    logic      misaligned;
    logic      accept;
    logic      head_vld;

    always_comb begin
        new_entry.addr   = {St_Addr[31:2], 2'b00};
        new_entry.wdata  = St_Din;
        new_entry.byteen = BE_WORD;
        case (St_Op)
            ST_OP_SH: begin
                new_entry.wdata  = {2{St_Din[15:0]}};
                new_entry.byteen = St_Addr[1] ? BE_HALF_HI : BE_HALF_LO;
            end
            ST_OP_SB: begin
                new_entry.wdata  = {4{St_Din[7:0]}};
                new_entry.byteen = BE_BYTE0 << St_Addr[1:0];
            end
            default: ;
        endcase
    end

    assign misaligned = ((St_Op == ST_OP_SW) && (St_Addr[1:0] != 2'b00)) ||
                        ((St_Op == ST_OP_SH) && St_Addr[0]);

`ifdef STORE_ALIGN_CHECK_EN
    assign Exc_AdES = St_Valid & misaligned;
`else
    // Misaligned stores are accepted and simply land on the aligned-down word.
    assign Exc_AdES = 1'b0;
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

    assign accept = St_Valid & St_Ready & st_op_legal(St_Op) & ~Exc_AdES;

    store_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_vld_i (accept),
        .push_dat_i (new_entry),
        .push_rdy_o (St_Ready),
        .pop_vld_o  (head_vld),
        .pop_rdy_i  (Bus_Ack),
        .pop_dat_o  (head)
    );

    assign Bus_Req    = head_vld;
    assign Idle       = ~head_vld;
    assign Bus_Addr   = head.addr;
    assign Bus_Wdata  = head.wdata;
    assign Bus_Byteen = head.byteen;

endmodule
